// File: rtl/matrix_mult_sequencer.sv
// matrix_mult_sequencer: feeds operand sets to a 2x2 matrix multiplier and returns one accumulated result per batch
module matrix_mult_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_last,
  output logic [31:0] mm_a,
  output logic [31:0] mm_b,
  output logic        mm_start,
  output logic        mm_accumulate,
  input  logic [63:0] mm_c,
  input  logic        mm_done,
  input  logic        mm_overflow,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_c,
  output logic        res_overflow,
  output logic [7:0]  res_count,
  output logic        res_timeout
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [TO_W-1:0] timer;
  logic last, accept, done_hit, to_hit;
  assign accept = in_valid & in_ready;
  assign done_hit = (state == WAIT) & mm_done;
  // done wins over a timeout landing in the same cycle
  assign to_hit = (state == WAIT) & ~mm_done & (timer == TO_W'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = mm_done ? (last ? DONE : IDLE) : (to_hit ? DONE : WAIT);
      DONE:    state_nx = res_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready = (state == IDLE) & ~rst;
    mm_start = state == ISSUE;
    res_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mm_a <= '0;
      mm_b <= '0;
      mm_accumulate <= 1'b0;
      last <= 1'b0;
      timer <= '0;
      res_c <= '0;
      res_overflow <= 1'b0;
      res_count <= '0;
      res_timeout <= 1'b0;
    end else begin
      if (accept) begin
        mm_a <= in_a;
        mm_b <= in_b;
        mm_accumulate <= res_count != 8'd0;
        last <= in_last;
        timer <= '0;
      end
      if (state == WAIT) timer <= timer + 1'b1;
      if (done_hit) begin
        res_c <= mm_c;
        res_overflow <= res_overflow | mm_overflow;
        res_count <= res_count + {7'd0, ~&res_count};
      end
      if (to_hit) res_timeout <= 1'b1;
      if (res_valid & res_ready) begin
        res_count <= '0;
        res_overflow <= 1'b0;
        res_timeout <= 1'b0;
        mm_accumulate <= 1'b0;
      end
    end
endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// tb_matrix_mult_sequencer: sequencer driving a behavioural 5-cycle multiplier, checked against a batch-level sum-of-products model
module tb_matrix_mult_sequencer;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_last = 0, res_ready = 0;
  logic [31:0] in_a = 0, in_b = 0;
  logic [31:0] mm_a, mm_b;
  logic mm_start, mm_accumulate, mm_done, in_ready, res_valid, res_overflow, res_timeout;
  logic [63:0] res_c, mm_c = 0;
  logic mm_overflow = 0;
  logic [7:0] res_count;
  int n_cmp = 0, n_err = 0;

  matrix_mult_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mm_a(mm_a), .mm_b(mm_b), .mm_start(mm_start), .mm_accumulate(mm_accumulate),
    .mm_c(mm_c), .mm_done(mm_done), .mm_overflow(mm_overflow), .res_valid(res_valid),
    .res_ready(res_ready), .res_c(res_c), .res_overflow(res_overflow), .res_count(res_count),
    .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  function automatic int prod(input logic [31:0] a, input logic [31:0] b, input int e);
    int i = e / 2;
    int j = e % 2;
    return int'(a[8*(2*i)+:8]) * int'(b[8*j+:8]) + int'(a[8*(2*i+1)+:8]) * int'(b[8*(2+j)+:8]);
  endfunction

  // multiplier stand-in: done 5 cycles after start, 16-bit wrapping accumulate
  int cd = 0, s;
  logic stall = 0, no;
  logic [63:0] nc;
  always @(posedge clk) begin
    if (mm_start) begin
      no = 0;
      nc = 0;
      for (int e = 0; e < 4; e++) begin
        s = (mm_accumulate ? int'(mm_c[16*e+:16]) : 0) + prod(mm_a, mm_b, e);
        nc[16*e+:16] = s[15:0];
        no = no | (s > 65535);
      end
      mm_c <= nc;
      mm_overflow <= no;
      cd <= 5;
    end else if (cd > 0) cd <= cd - 1;
  end
  assign mm_done = (cd == 1) && !stall;

  int r_tot [4];
  int r_cnt = 0;
  logic r_ovf = 0, r_to = 0;
  logic [63:0] r_c = 0;

  function automatic void ref_clear();
    for (int e = 0; e < 4; e++) r_tot[e] = 0;
    r_cnt = 0;
    r_ovf = 0;
    r_to = 0;
  endfunction

  function automatic void ref_add(input logic [31:0] a, input logic [31:0] b);
    for (int e = 0; e < 4; e++) begin
      r_tot[e] += prod(a, b, e);
      r_c[16*e+:16] = r_tot[e][15:0];
      if (r_tot[e] > 65535) r_ovf = 1;
    end
    r_cnt = r_cnt < 255 ? r_cnt + 1 : 255;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // mode 0: nominal round trip, 1: multiplier stalled, 2: return right after the start pulse
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic last, input int mode);
    int t = 0;
    logic exp_acc;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    chk("in_ready_wait", 64'(t < 100), 64'(1));
    exp_acc = r_cnt != 0;
    stall = mode == 1;
    in_a = a; in_b = b; in_last = last; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("mm_a", 64'(mm_a), 64'(a));
    chk("mm_b", 64'(mm_b), 64'(b));
    chk("mm_accumulate", 64'(mm_accumulate), 64'(exp_acc));
    chk("mm_start_hi", 64'(mm_start), 64'(1));
    @(negedge clk);
    chk("mm_start_lo", 64'(mm_start), 64'(0));
    if (mode == 1) begin
      t = 2;
      while (!res_valid && t < 100) begin @(negedge clk); t++; end
      chk("timeout_latency", 64'(t), 64'(TIMEOUT + 2));
      r_to = 1;
    end else if (mode == 0) begin
      repeat (4) @(negedge clk);
      chk("t6_busy", 64'({res_valid, in_ready}), 64'(0));
      @(negedge clk);
      ref_add(a, b);
      chk("t7_state", 64'({res_valid, in_ready}), last ? 64'(2) : 64'(1));
      chk("mm_hold", {mm_a, mm_b}, {a, b});
    end
  endtask

  task automatic recv(input int hold);
    int t = 0;
    while (!res_valid && t < 100) begin @(negedge clk); t++; end
    chk("res_valid_wait", 64'(t < 100), 64'(1));
    chk("res_c", res_c, r_c);
    chk("res_overflow", 64'(res_overflow), 64'(r_ovf));
    chk("res_count", 64'(res_count), 64'(r_cnt));
    chk("res_timeout", 64'(res_timeout), 64'(r_to));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_flags", 64'({res_valid, in_ready, res_overflow, res_timeout, res_count}),
          64'({1'b1, 1'b0, r_ovf, r_to, 8'(r_cnt)}));
      chk("hold_c", res_c, r_c);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("post_handshake", 64'({res_valid, in_ready, res_overflow, res_timeout, res_count, mm_accumulate}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0}));
    chk("res_c_kept", res_c, r_c);
    ref_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int n;
    ref_clear();
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 64'({in_ready, mm_start, mm_accumulate, res_valid, res_overflow, res_timeout, res_count}), 64'(0));
    chk("reset_data", {mm_a, mm_b} | res_c, 64'(0));
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));

    send(32'h04030201, 32'h08070605, 1, 0);
    recv(0);
    chk("single_c", res_c, 64'h0032_002B_0016_0013);

    for (int i = 0; i < 3; i++) send(32'h04030201, 32'h08070605, i == 2, 0);
    recv(0);
    chk("batch3_c", res_c, 64'h0096_0081_0042_0039);

    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0);
    chk("max_overflow", 64'(res_overflow), 64'(1));
    recv(0);
    chk("max_c", res_c, 64'hFC02_FC02_FC02_FC02);

    send($urandom, $urandom, 1, 0);
    recv(10);

    send($urandom, $urandom, 0, 0);
    send($urandom, $urandom, 1, 1);
    recv(0);
    stall = 0;
    send($urandom, $urandom, 1, 0);
    recv(1);

    send($urandom, $urandom, 1, 2);
    @(negedge clk);
    rst = 1;
    #1;
    chk("async_reset_ctrl", 64'({in_ready, mm_start, mm_accumulate, res_valid, res_count}), 64'(0));
    chk("async_reset_data", {mm_a, mm_b} | res_c, 64'(0));
    @(negedge clk);
    rst = 0;
    ref_clear();
    r_c = 0;
    #1;
    chk("ready_after_midwait_reset", 64'(in_ready), 64'(1));
    repeat (5) @(negedge clk);
    chk("late_done_ignored", 64'({res_valid, in_ready, res_count}), 64'({1'b0, 1'b1, 8'd0}));
    chk("late_done_c", res_c, 64'(0));
    send($urandom, $urandom, 1, 0);
    recv(0);

    for (int i = 0; i < 257; i++) send($urandom & 32'h03030303, $urandom & 32'h03030303, i == 256, 0);
    chk("count_saturated", 64'(res_count), 64'(255));
    recv(0);

    for (int k = 0; k < 20; k++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        a = $urandom;
        b = $urandom;
        send(a, b, i == n - 1, 0);
      end
      recv($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_mult_sequencer.md
# matrix_mult_sequencer

- Host-side driver for the 2x2 matrix multiplier. It accepts operand sets on a valid/ready stream and drives the multiplier's operand, start and accumulate pins.
- It waits for the multiplier's done pulse, captures the 16-bit results and overflow, and returns one result per batch on a valid/ready output stream.
- It sits between the operand source and the multiplier, and owns the multiplier's control protocol: start pulse, operand hold, accumulate sequencing and done detection.

## Interface
- TIMEOUT, 16: cycles to wait in WAIT for mm_done before aborting (must be ≥ 6).
- TO_W, 5: timer width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- in_valid  in  1  operand set valid
- in_ready  out  1  operand set accepted when in_valid & in_ready
- in_a  in  32  {a11,a10,a01,a00}, 8 bits each, unsigned
- in_b  in  32  {b11,b10,b01,b00}, 8 bits each, unsigned
- in_last  in  1  operand set is the final element of a batch
- mm_a  out  32  to multiplier a00..a11, same packing as in_a
- mm_b  out  32  to multiplier b00..b11, same packing as in_b
- mm_start  out  1  one-cycle start pulse to multiplier
- mm_accumulate  out  1  multiplier accumulate control
- mm_c  in  64  {c11,c10,c01,c00} from multiplier
- mm_done  in  1  multiplier done pulse
- mm_overflow  in  1  multiplier overflow flag
- res_valid  out  1  batch result valid
- res_ready  in  1  result consumed when res_valid & res_ready
- res_c  out  64  last captured mm_c
- res_overflow  out  1  OR of mm_overflow over the batch
- res_count  out  8  elements completed in the batch, saturates at 255
- res_timeout  out  1  batch aborted on timeout

## Operation
- States:
  - IDLE: in_ready = 1.
  - ISSUE: mm_start = 1.
  - WAIT: timer runs.
  - DONE: res_valid = 1.
- Reset: state IDLE. All registered outputs are 0: mm_a, mm_b, mm_start, mm_accumulate, res_valid, res_c, res_overflow, res_count, res_timeout. Timer = 0.
- in_ready = (state == IDLE) & ~rst.
- IDLE, on accept:
  - Register in_a → mm_a and in_b → mm_b.
  - mm_accumulate = (res_count != 0). The first element of a batch overwrites the multiplier's C; later elements accumulate into it.
  - Latch in_last, clear the timer, go to ISSUE.
- ISSUE: lasts exactly one cycle, then WAIT.
- WAIT: the timer increments every cycle. On mm_done:
  - Capture res_c = mm_c.
  - res_overflow |= mm_overflow.
  - res_count += 1, saturating at 255.
  - Go to DONE if the latched last = 1, else IDLE.
- WAIT, timer reaches TIMEOUT with no mm_done: set res_timeout = 1, leave res_c, res_overflow and res_count unchanged, go to DONE.
- DONE: on res_ready:
  - Clear res_count, res_overflow and res_timeout, and set mm_accumulate = 0, all on the handshake edge.
  - Go to IDLE.
  - res_c keeps its value until the next capture.
- mm_a, mm_b and mm_accumulate hold stable from accept until the next accept. The multiplier re-samples its inputs every cycle, so this hold is mandatory.
- mm_done is ignored in IDLE, ISSUE and DONE.
- Arithmetic is done in the multiplier. The sequencer never modifies result data; res_c is the low 16 bits per element as delivered.

## Timing
- Accept edge at cycle T; mm_start is high in cycle T+1 only.
- The multiplier's nominal round trip is mm_done high 5 cycles after mm_start, in cycle T+6. The capture edge ends that cycle.
- Non-last element: in_ready is high again in cycle T+7.
- Last element: res_valid is high from T+7.
- Throughput is one element per 7 cycles.
- res_valid and the res_* outputs are stable while res_valid = 1 and res_ready = 0.
- mm_done in the same cycle the timer reaches TIMEOUT: done wins, and res_timeout stays 0.
- An asynchronous rst at any state, including mid-WAIT, forces IDLE and reset values immediately. A late mm_done after reset release is ignored because the state is IDLE.

## Test plan
The bench connects the sequencer to the matrix multiplier RTL, with a stall model for the timeout case.

- Single element, in_last = 1, a = {4,3,2,1}, b = {8,7,6,5}:
  - mm_start is high exactly one cycle.
  - res_c = {50,43,22,19}, res_count = 1, res_overflow = 0, res_timeout = 0.
- Batch of 3 identical elements as above:
  - mm_accumulate = 0, then 1, then 1.
  - res_c = {150,129,66,57}, res_count = 3, with a single res_valid.
- All operands 255, single element: res_c = {64514,64514,64514,64514}, res_overflow = 1.
- res_ready held low for 10 cycles after res_valid:
  - res_* stay stable and in_ready stays 0.
  - Accept occurs the cycle after res_ready rises.
- Multiplier stalled with mm_done forced to 0:
  - res_valid rises TIMEOUT cycles into WAIT with res_timeout = 1.
  - The next batch's first element drives mm_accumulate = 0.
- rst pulsed 2 cycles after mm_start:
  - All outputs go to reset values and in_ready = 1 after release.
  - The following mm_done is ignored, and a fresh single element produces the correct res_c.
